// File: rtl/chip8_pkg.sv
// chip8_pkg: shared types and constants for the CHIP-8 cycle sequencer.
// Provides the sequencer FSM state encoding, the timer rate and a byte type.
package chip8_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    EXEC      = 3'd2,
    CHECK     = 3'd3,
    WAIT_DONE = 3'd4,
    WAIT_KEY  = 3'd5
  } seq_state_t;
  localparam int TIMER_HZ = 60;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/chip8_down_timer.sv
// chip8_down_timer: 8-bit loadable down counter that stops at zero.
// Ports: clk, rst_n (sync active-low), load/value (load wins over tick),
//        tick (decrement strobe), count (current value).
module chip8_down_timer
  import chip8_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  tick,
  input  byte_t value,
  output byte_t count
);
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (load) count <= value;
    else if (tick && count != '0) count <= count - 8'd1;
endmodule

// File: rtl/chip8_cycle_sequencer.sv
// chip8_cycle_sequencer: paces CHIP-8 instruction issue and owns the 60 Hz timers.
// Ports: clk_in/rst_in_n (sync active-low); run_in/step_in issue control;
//        fetch_req_out/fetch_ack_in fetch handshake; exec_en_out strobe;
//        exec_busy_in/exec_done_in and wait_key_in/key_pressed_in stall inputs;
//        dt/st load via timer_value_in; dt_out, st_out, beep_out, frame_tick_out;
//        instr_count_out retired count; state_out debug state.
module chip8_cycle_sequencer
  import chip8_pkg::*;
#(
  parameter int INSTR_DIV = 2000,
  parameter int TIMER_DIV = 16667
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        run_in,
  input  logic        step_in,
  output logic        fetch_req_out,
  input  logic        fetch_ack_in,
  output logic        exec_en_out,
  input  logic        exec_busy_in,
  input  logic        exec_done_in,
  input  logic        wait_key_in,
  input  logic        key_pressed_in,
  input  logic        dt_load_in,
  input  logic        st_load_in,
  input  byte_t       timer_value_in,
  output byte_t       dt_out,
  output byte_t       st_out,
  output logic        beep_out,
  output logic        frame_tick_out,
  output logic [31:0] instr_count_out,
  output logic [2:0]  state_out
);
  localparam int PW = $clog2(INSTR_DIV);
  localparam int TW = $clog2(TIMER_DIV);
  seq_state_t state, state_next;
  logic [PW-1:0] pace_cnt;
  logic [TW-1:0] tick_cnt;
  logic pending, start, retire, pace_wrap, tick_wrap, dec;
  assign pace_wrap = run_in && pace_cnt == PW'(INSTR_DIV - 1);
  assign tick_wrap = tick_cnt == TW'(TIMER_DIV - 1);
  assign dec = tick_wrap && run_in;
  assign fetch_req_out = state == FETCH;
  assign exec_en_out = state == EXEC;
  assign state_out = state;
  always_ff @(posedge clk_in)
    if (!rst_in_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    start = 1'b0;
    retire = 1'b0;
    case (state)
      IDLE: if ((run_in && pending) || (!run_in && step_in)) begin
        state_next = FETCH;
        start = 1'b1;
      end
      FETCH: state_next = fetch_ack_in ? EXEC : FETCH;
      EXEC: state_next = CHECK;
      CHECK: begin
        state_next = exec_busy_in ? WAIT_DONE : wait_key_in ? WAIT_KEY : IDLE;
        retire = !exec_busy_in && !wait_key_in;
      end
      WAIT_DONE: begin
        state_next = exec_done_in ? IDLE : WAIT_DONE;
        retire = exec_done_in;
      end
      WAIT_KEY: begin
        state_next = key_pressed_in ? IDLE : WAIT_KEY;
        retire = key_pressed_in;
      end
      default: state_next = IDLE;
    endcase
  end
  // A start only happens from IDLE with pending set (or stepping with pending
  // already 0), so clearing on start also drops a wrap landing on that cycle.
  always_ff @(posedge clk_in)
    if (!rst_in_n) begin
      pace_cnt <= '0;
      pending <= 1'b0;
      tick_cnt <= '0;
      frame_tick_out <= 1'b0;
      instr_count_out <= '0;
      beep_out <= 1'b0;
    end else begin
      pace_cnt <= (!run_in || pace_wrap) ? '0 : pace_cnt + PW'(1);
      pending <= run_in && !start && (pending || pace_wrap);
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
      frame_tick_out <= tick_wrap;
      instr_count_out <= instr_count_out + 32'(retire);
      // Mirrors the sound timer's next value so beep tracks st_out exactly.
      beep_out <= st_load_in ? timer_value_in != '0 : dec ? st_out > 8'd1 : st_out != '0;
    end
  chip8_down_timer u_dt (
    .clk(clk_in), .rst_n(rst_in_n), .load(dt_load_in), .tick(dec),
    .value(timer_value_in), .count(dt_out)
  );
  chip8_down_timer u_st (
    .clk(clk_in), .rst_n(rst_in_n), .load(st_load_in), .tick(dec),
    .value(timer_value_in), .count(st_out)
  );
endmodule

// File: tb/tb_chip8_cycle_sequencer.sv
// tb_chip8_cycle_sequencer: directed self-checking bench for chip8_cycle_sequencer.
module tb_chip8_cycle_sequencer;
  logic clk = 1'b0;
  logic rst_in_n, run_in, step_in, fetch_ack_in, exec_busy_in, exec_done_in;
  logic wait_key_in, key_pressed_in, dt_load_in, st_load_in;
  logic [7:0] timer_value_in, dt_out, st_out;
  logic fetch_req_out, exec_en_out, beep_out, frame_tick_out;
  logic [31:0] instr_count_out;
  logic [2:0] state_out;
  int total = 0, passed = 0, cyc = 0, execs = 0;
  bit mon = 0;

  chip8_cycle_sequencer #(.INSTR_DIV(4), .TIMER_DIV(10)) dut (
    .clk_in(clk), .rst_in_n(rst_in_n), .run_in(run_in), .step_in(step_in),
    .fetch_req_out(fetch_req_out), .fetch_ack_in(fetch_ack_in),
    .exec_en_out(exec_en_out), .exec_busy_in(exec_busy_in),
    .exec_done_in(exec_done_in), .wait_key_in(wait_key_in),
    .key_pressed_in(key_pressed_in), .dt_load_in(dt_load_in),
    .st_load_in(st_load_in), .timer_value_in(timer_value_in),
    .dt_out(dt_out), .st_out(st_out), .beep_out(beep_out),
    .frame_tick_out(frame_tick_out), .instr_count_out(instr_count_out),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_in_n ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mon) chk("frame_tick", frame_tick_out, (cyc != 0 && cyc % 10 == 0));
    if (!rst_in_n) execs = 0;
    else if (exec_en_out) execs++;
  end

  task automatic wait_exec();
    int n = 0;
    while (!exec_en_out && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("exec_seen", exec_en_out, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] ex = 0, fr = 0;
    int wd = 0, fq = 0, pulses = 0, wk = 0;
    rst_in_n = 0; run_in = 0; step_in = 0; fetch_ack_in = 1;
    exec_busy_in = 0; exec_done_in = 0; wait_key_in = 0; key_pressed_in = 0;
    dt_load_in = 0; st_load_in = 0; timer_value_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_out, 0);
    chk("rst_fetch", fetch_req_out, 0);
    chk("rst_exec", exec_en_out, 0);
    chk("rst_count", instr_count_out, 0);
    chk("rst_beep", beep_out, 0);
    chk("rst_dt", dt_out, 0);
    mon = 1; rst_in_n = 1; run_in = 1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      ex[i] = exec_en_out;
      fr[i] = fetch_req_out;
    end
    chk("exec_pattern", ex, 32'h0044_4440);
    chk("fetch_pattern", fr, 32'h0022_2220);
    chk("count_after_20", instr_count_out, 5);
    // multi-cycle stall
    wait_exec();
    exec_busy_in = 1;
    @(negedge clk);
    chk("busy_check_state", state_out, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wd += (state_out == 3'd4);
      fq += fetch_req_out;
    end
    chk("wait_done_cycles", wd, 10);
    chk("no_fetch_in_wait", fq, 0);
    exec_busy_in = 0; exec_done_in = 1;
    @(negedge clk);
    chk("done_idle", state_out, 0);
    chk("done_count", instr_count_out, 6);
    exec_done_in = 0;
    @(negedge clk);
    chk("fetch_after_idle", fetch_req_out, 1);
    // run drops mid-instruction
    run_in = 0;
    repeat (4) @(negedge clk);
    chk("rundrop_idle", state_out, 0);
    chk("rundrop_count", instr_count_out, 7);
    fq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fq += fetch_req_out;
    end
    chk("stopped_no_fetch", fq, 0);
    // single steps; step held into FETCH must not add an instruction
    for (int i = 0; i < 30; i++) begin
      step_in = (i % 10 == 0) || (i == 1);
      @(negedge clk);
      pulses += exec_en_out;
    end
    step_in = 0;
    chk("step_pulses", pulses, 3);
    chk("step_count", instr_count_out, 10);
    // re-enable: pace restarts from zero
    run_in = 1;
    fr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fr[i] = fetch_req_out;
    end
    chk("reenable_fetch", fr, 32'h10);
    // timers
    while (cyc % 10 != 2) @(negedge clk);
    dt_load_in = 1; timer_value_in = 3;
    @(negedge clk);
    dt_load_in = 0; st_load_in = 1; timer_value_in = 2;
    @(negedge clk);
    st_load_in = 0;
    chk("load_dt", dt_out, 3);
    chk("load_st", st_out, 2);
    chk("load_beep", beep_out, 1);
    while (cyc % 10 != 9) @(negedge clk);
    chk("pre_tick_st", st_out, 2);
    @(negedge clk);
    chk("tick1_dt", dt_out, 2);
    chk("tick1_st", st_out, 1);
    chk("tick1_beep", beep_out, 1);
    repeat (10) @(negedge clk);
    chk("tick2_dt", dt_out, 1);
    chk("tick2_st", st_out, 0);
    chk("tick2_beep", beep_out, 0);
    repeat (10) @(negedge clk);
    chk("tick3_dt", dt_out, 0);
    repeat (10) @(negedge clk);
    chk("tick4_dt", dt_out, 0);
    chk("tick4_st", st_out, 0);
    while (cyc % 10 != 9) @(negedge clk);
    dt_load_in = 1; timer_value_in = 5;
    @(negedge clk);
    dt_load_in = 0;
    chk("load_on_tick_dt", dt_out, 5);
    while (cyc % 10 != 9) @(negedge clk);
    st_load_in = 1; timer_value_in = 7;
    @(negedge clk);
    st_load_in = 0;
    chk("load_on_tick_st", st_out, 7);
    chk("dec_beside_load_dt", dt_out, 4);
    chk("load_beep7", beep_out, 1);
    run_in = 0;
    repeat (12) @(negedge clk);
    chk("frozen_dt", dt_out, 4);
    chk("frozen_st", st_out, 7);
    // key wait
    run_in = 1;
    wait_exec();
    wait_key_in = 1;
    @(negedge clk);
    chk("key_check_state", state_out, 3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      wk += (state_out == 3'd5);
    end
    chk("wait_key_cycles", wk, 50);
    wait_key_in = 0; key_pressed_in = 1;
    @(negedge clk);
    key_pressed_in = 0;
    chk("key_idle", state_out, 0);
    chk("key_count", instr_count_out, execs);
    // reset while stalled
    wait_exec();
    exec_busy_in = 1;
    repeat (2) @(negedge clk);
    chk("pre_reset_wait_done", state_out, 4);
    rst_in_n = 0;
    @(negedge clk);
    chk("mid_rst_state", state_out, 0);
    chk("mid_rst_fetch", fetch_req_out, 0);
    chk("mid_rst_exec", exec_en_out, 0);
    chk("mid_rst_count", instr_count_out, 0);
    chk("mid_rst_dt", dt_out, 0);
    chk("mid_rst_st", st_out, 0);
    chk("mid_rst_beep", beep_out, 0);
    chk("mid_rst_frame", frame_tick_out, 0);
    rst_in_n = 1; exec_busy_in = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_state", state_out, 0);
    chk("post_rst_count", instr_count_out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
